axi_lite_ram: RTL
=================

# axi_lite_ram

Word-organised AXI-lite-style memory slave that sits directly downstream of the `riscv` core's memory master port and serves both its instruction fetches and its loads and stores. It has one clock, a single-entry read channel and a single-entry write channel, which operate independently. Byte strobes are honoured, and addresses outside the configured window return an error response. Its port names and channel semantics mirror the core's master port one-to-one, so the two connect by name in the top level and in the formal and simulation harnesses.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, ≥ 4.
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `awvalid`  in  1: master presents a write address.
- `awready`  out  1: slave accepts the write address.
- `awaddress`  in  32: write byte address.
- `awprot`  in  3: ignored.
- `wvalid`  in  1: master presents write data.
- `wready`  out  1: slave accepts write data.
- `wdata`  in  32: write data.
- `wstrb`  in  4: byte enables; `wstrb[i]` enables `wdata[8i+7:8i]`.
- `bready`  out  1: slave presents the write response.
- `bvalid`  in  1: master has taken the response.
- `bresp`  out  2: 2'b00 OKAY, 2'b10 SLVERR.
- `arvalid`  in  1: master presents a read address.
- `arready`  out  1: slave accepts the read address.
- `araddress`  in  32: read byte address.
- `arprot`  in  3: ignored.
- `rvalid`  out  1: read data is valid.
- `rready`  in  1: master takes the read data.
- `rdata`  out  32: read data.
- `rresp`  out  2: 2'b00 OKAY, 2'b10 SLVERR.

## Operation
- **Address decode:**
  - `idx = (addr - ADDR_BASE) >> 2`; `addr[1:0]` is ignored.
  - The address is in range when `addr >= ADDR_BASE` and `addr - ADDR_BASE < DEPTH_WORDS*4`, computed as an unsigned 32-bit comparison.
- **Write FSM: W_IDLE → W_RESP → W_IDLE.**
  - In W_IDLE the AW and W handshakes are accepted independently. Each one is latched into a holding register with its own "have" flag.
  - `awready` = W_IDLE && !have_aw. `wready` = W_IDLE && !have_w.
  - The commit edge is the edge on which both flags are, or become, set; AW and W accepted in the same cycle count as one edge.
  - On the commit edge:
    - If the address is in range, each byte with its strobe set is written, and `bresp` = 00.
    - If the address is out of range, memory is untouched and `bresp` = 10.
    - `wstrb` = 0 with an in-range address writes nothing and returns OKAY.
    - Both flags are cleared and the FSM goes to W_RESP.
  - W_RESP: `bready` = 1 and `bresp` is held stable. On `bready && bvalid` the FSM returns to W_IDLE.
- **Read FSM: R_IDLE → R_DATA → R_IDLE.**
  - `arready` = R_IDLE.
  - On `arvalid && arready`:
    - `rdata` is registered from mem[idx], or 0 if out of range.
    - `rresp` is registered as 00 or 10.
    - The FSM goes to R_DATA.
  - R_DATA: `rvalid` = 1 and `rdata`/`rresp` are held stable. On `rvalid && rready` the FSM returns to R_IDLE.
- **Read/write collision:** a read accepted on the same edge as a write commit to the same word returns the pre-write data (read-before-write). Any read accepted after the commit edge sees the new data.
- **Reset (`reset` = 0 at a rising edge):**
  - Both FSMs go to idle and the have flags, `bready`, `rvalid`, `bresp`, `rresp` and `rdata` are cleared to 0.
  - `awready`, `wready` and `arready` are 0 while reset is asserted.
  - Memory contents are retained. An in-flight transaction is dropped with no response.

## Timing
- **Output values:** every output is 0 during reset. In the first cycle after reset is released, `awready` = `wready` = `arready` = 1.
- **Read latency:** AR accepted at edge T → `rvalid` = 1 during cycle T+1. Back-to-back throughput is one read per 2 cycles, because `arready` is low in R_DATA.
- **Write latency:** commit edge T → `bready` = 1 during cycle T+1. The next AW/W can be accepted the cycle after `bvalid && bready`.
- **Backpressure:** `rvalid` and `bready` stay high indefinitely until they are acknowledged; no timeout.
- **Independence:** reads and writes may be in flight simultaneously; neither channel stalls the other.
- **Combinational paths:** the `*ready` outputs depend only on registered state. There is no combinational path from any input to any output.

## Test plan
- **Aligned write then read:**
  - Stimulus: write 0x100 ← 0xDEADBEEF with strobe 4'hF, then read 0x100.
  - Required: `bready`/OKAY one cycle after commit; `rvalid` one cycle after AR with `rdata` = 0xDEADBEEF and `rresp` = 00.
- **Partial strobe:**
  - Stimulus: 0x104 holds 0x11223344; write `wdata` 0xAABBCCDD with `wstrb` 4'b0101, then read 0x104.
  - Required: `rdata` = 0x11BB33DD.
- **AW and W skew:**
  - Stimulus: W accepted 3 cycles before AW.
  - Required: `wready` drops after the W handshake; commit happens on the AW edge; `bready` the next cycle; `bvalid` held low for 5 cycles keeps `bready`/`bresp` stable.
- **Out of range:**
  - Stimulus: write and read at `ADDR_BASE + DEPTH_WORDS*4`.
  - Required: `bresp` = 10, `rresp` = 10, `rdata` = 0; word 0 is unchanged on readback.
- **Collision:**
  - Stimulus: 0x200 holds 0x0; AR for 0x200 is accepted on the same edge as a write commit of 0x55 to 0x200.
  - Required: `rdata` = 0x0; a following read returns 0x55.
- **Reset mid-operation:**
  - Stimulus: assert `reset` = 0 for 1 cycle while in R_DATA and W_RESP.
  - Required: `rvalid` = `bready` = 0 the next cycle; all ready outputs = 1 after release; previously written data still reads back.

Source files
------------

// File: rtl/axi_lite_ram.sv
// Word-organised AXI-lite-style RAM slave with independent single-entry read and write channels.
// Byte strobes are honoured; addresses outside the configured window get SLVERR.
module axi_lite_ram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddress,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bready,
    input  logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddress,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic              live;
    logic              have_aw, have_w;
    logic [31:0]       aw_hold, w_hold_data;
    logic [3:0]        w_hold_strb;
    logic              aw_fire, w_fire, ar_fire, commit;
    logic [31:0]       w_addr_eff, w_data_eff;
    logic [3:0]        w_strb_eff;
    logic [32:0]       w_off, r_off;
    logic              w_in_range, r_in_range;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              unused_bits;

    // Registered copy of reset keeps the ready outputs low through the reset cycle without a combinational path.
    always_ff @(posedge clk) begin
        live <= reset;
    end

    assign awready = live && (w_state == W_IDLE) && !have_aw;
    assign wready  = live && (w_state == W_IDLE) && !have_w;
    assign arready = live && (r_state == R_IDLE);
    assign bready  = (w_state == W_RESP);
    assign rvalid  = (r_state == R_DATA);

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    assign w_addr_eff = have_aw ? aw_hold : awaddress;
    assign w_data_eff = have_w ? w_hold_data : wdata;
    assign w_strb_eff = have_w ? w_hold_strb : wstrb;
    assign commit     = reset && (w_state == W_IDLE) && (have_aw || aw_fire) && (have_w || w_fire);

    // A borrow out of the 33-bit subtraction always lands at or above SPAN, so one compare covers both bounds.
    assign w_off      = {1'b0, w_addr_eff} - {1'b0, ADDR_BASE};
    assign r_off      = {1'b0, araddress} - {1'b0, ADDR_BASE};
    assign w_in_range = (w_off < SPAN);
    assign r_in_range = (r_off < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign r_idx      = r_off[IDX_W+1:2];

    assign unused_bits = ^{awprot, arprot, w_off, r_off};

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: if (bvalid) w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: if (ar_fire) r_next = R_DATA;
            R_DATA: if (rready)  r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            have_aw     <= 1'b0;
            have_w      <= 1'b0;
            aw_hold     <= '0;
            w_hold_data <= '0;
            w_hold_strb <= '0;
            bresp       <= 2'b00;
        end else if (commit) begin
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            bresp   <= w_in_range ? 2'b00 : 2'b10;
        end else begin
            if (aw_fire) begin
                have_aw <= 1'b1;
                aw_hold <= awaddress;
            end
            if (w_fire) begin
                have_w      <= 1'b1;
                w_hold_data <= wdata;
                w_hold_strb <= wstrb;
            end
        end
    end

    // Memory has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_eff[b]) mem[w_idx][8*b +: 8] <= w_data_eff[8*b +: 8];
            end
        end
    end

    // Reading the array with non-blocking writes alongside gives read-before-write on a same-edge collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
            rresp <= 2'b00;
        end else if (ar_fire) begin
            rdata <= r_in_range ? mem[r_idx] : 32'h0;
            rresp <= r_in_range ? 2'b00 : 2'b10;
        end
    end

endmodule
